// File: rtl/c17_resp_misr.sv
// Response compactor for the C17 benchmark circuit: an 8-bit MISR that folds
// each 2-bit response into a signature and compares it with a golden value.
module c17_resp_misr #(
  parameter logic [7:0] SEED = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] num_patterns,
  input  logic [7:0] golden,
  input  logic       in_valid,
  input  logic [1:0] resp,
  output logic       in_ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] signature,
  output logic       pass
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Taps 7,5,4,3; the response lands on the two low bits after the shift.
  function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [1:0] r);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb} ^ {6'b000000, r};
  endfunction

  state_t     state_q, state_d;
  logic [7:0] sig_q, sig_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] gold_q, gold_d;
  logic       pass_q, pass_d;
  logic       busy_q, done_q;
  logic [7:0] step_s;

  // Next-state and datapath decisions for the three-state run controller.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    gold_d  = gold_q;
    pass_d  = pass_q;
    step_s  = misr_step(sig_q, resp);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          sig_d  = SEED;
          cnt_d  = num_patterns;
          gold_d = golden;
          if (num_patterns == 8'd0) begin
            state_d = ST_DONE;
            pass_d  = (SEED == golden);
          end else begin
            state_d = ST_RUN;
            pass_d  = 1'b0;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          sig_d = step_s;
          cnt_d = cnt_q - 8'd1;
          // Count is never zero here, so the decrement cannot wrap.
          if (cnt_q == 8'd1) begin
            state_d = ST_DONE;
            pass_d  = (step_s == gold_q);
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and decoded status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sig_q   <= 8'h00;
      cnt_q   <= 8'h00;
      gold_q  <= 8'h00;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      gold_q  <= gold_d;
      pass_q  <= pass_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign in_ready  = busy_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign signature = sig_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_c17_resp_misr.sv
// Randomised self-checking bench for c17_resp_misr against a cycle-level
// reference model of the run/compaction rules.
module tb_c17_resp_misr;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] num_patterns;
  logic [7:0] golden;
  logic       in_valid;
  logic [1:0] resp;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic [7:0] signature;
  logic       pass;

  int checks = 0;
  int failures = 0;

  // Reference model: phase 0 = idle, 1 = compacting, 2 = finished.
  int m_phase = 0;
  int m_sig = 0;
  int m_left = 0;
  int m_gold = 0;
  int m_pass = 0;

  c17_resp_misr #(.SEED(8'h00)) dut (
    .clk(clk), .rst(rst), .start(start), .num_patterns(num_patterns),
    .golden(golden), .in_valid(in_valid), .resp(resp), .in_ready(in_ready),
    .busy(busy), .done(done), .signature(signature), .pass(pass)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_misr(input int s, input int r);
    int fb;
    fb = ^(s & 8'hB8);
    return (((s << 1) | fb) ^ r) & 8'hFF;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_phase = 0; m_sig = 0; m_left = 0; m_gold = 0; m_pass = 0;
    end else if (m_phase != 1 && start) begin
      m_sig  = 0;
      m_gold = golden;
      m_left = num_patterns;
      if (num_patterns == 0) begin
        m_phase = 2;
        m_pass  = (m_gold == 0);
      end else begin
        m_phase = 1;
        m_pass  = 0;
      end
    end else if (m_phase == 1 && in_valid) begin
      m_sig  = model_misr(m_sig, resp);
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_phase = 2;
        m_pass  = (m_sig == m_gold);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("signature", signature, m_sig);
    check_eq("busy", busy, m_phase == 1);
    check_eq("in_ready", in_ready, m_phase == 1);
    check_eq("done", done, m_phase == 2);
    if (m_phase == 2) check_eq("pass", pass, m_pass);
  endtask

  task automatic do_start(input int n, input int g);
    start = 1'b1; num_patterns = n[7:0]; golden = g[7:0];
    tick();
    start = 1'b0; num_patterns = 8'h00; golden = 8'h00;
  endtask

  task automatic send(input int r);
    in_valid = 1'b1; resp = r[1:0];
    tick();
    in_valid = 1'b0; resp = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int budget;
    rst = 1'b1; start = 1'b0; num_patterns = 8'h00; golden = 8'h00;
    in_valid = 1'b0; resp = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    check_eq("reset_sig", signature, 8'h00);
    check_eq("reset_done", done, 1'b0);

    // Single response, matching golden.
    do_start(1, 8'h01);
    send(2'b01);
    check_eq("r1_sig", signature, 8'h01);
    check_eq("r1_done", done, 1'b1);
    check_eq("r1_pass", pass, 1'b1);

    // Two responses, mismatching golden.
    do_start(2, 8'h05);
    send(2'b01);
    check_eq("r2_sig_a", signature, 8'h01);
    send(2'b10);
    check_eq("r2_sig_b", signature, 8'h00);
    check_eq("r2_done", done, 1'b1);
    check_eq("r2_pass", pass, 1'b0);

    // Three responses separated by idle gaps.
    do_start(3, 8'h09);
    tick();
    send(2'b11);
    check_eq("r3_sig_a", signature, 8'h03);
    tick(); tick();
    check_eq("r3_hold", signature, 8'h03);
    send(2'b11);
    check_eq("r3_sig_b", signature, 8'h05);
    tick();
    send(2'b11);
    check_eq("r3_sig_c", signature, 8'h09);
    check_eq("r3_pass", pass, 1'b1);

    // Zero-length run goes straight to DONE.
    do_start(0, 8'h00);
    check_eq("r0_done", done, 1'b1);
    check_eq("r0_pass", pass, 1'b1);
    check_eq("r0_busy", busy, 1'b0);

    // Reset mid-run aborts, then a fresh run completes.
    do_start(3, 8'h00);
    send(2'b11);
    do_reset();
    check_eq("abort_sig", signature, 8'h00);
    check_eq("abort_done", done, 1'b0);
    do_start(1, 8'h02);
    send(2'b10);
    check_eq("after_abort_pass", pass, 1'b1);

    // Start during RUN and in_valid during DONE/IDLE are ignored.
    do_start(3, 8'h09);
    send(2'b11);
    start = 1'b1; num_patterns = 8'h07; golden = 8'h00;
    tick();
    start = 1'b0;
    send(2'b11);
    send(2'b11);
    check_eq("ign_sig", signature, 8'h09);
    check_eq("ign_pass", pass, 1'b1);
    send(2'b11);
    check_eq("ign_done_sig", signature, 8'h09);
    do_reset();
    send(2'b11);
    check_eq("ign_idle_sig", signature, 8'h00);

    // Maximum-length run.
    do_start(255, 8'h00);
    budget = 0;
    while (m_phase == 1 && budget < 2000) begin
      send($urandom_range(0, 3));
      budget++;
    end
    check_eq("max_updates", budget, 255);

    // Randomised runs with gaps, stray starts and occasional aborts.
    for (int run = 0; run < 40; run++) begin
      int n;
      n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20);
      do_start(n, $urandom_range(0, 255));
      budget = 0;
      while (m_phase == 1 && budget < 500) begin
        in_valid = ($urandom_range(0, 3) != 0);
        resp     = $urandom_range(0, 3);
        start    = ($urandom_range(0, 7) == 0);
        num_patterns = $urandom_range(0, 255);
        golden   = $urandom_range(0, 255);
        rst      = ($urandom_range(0, 99) == 0);
        tick();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        budget++;
      end
      if (budget >= 500) check_eq("run_timeout", budget, 0);
      in_valid = 1'b1; resp = $urandom_range(0, 3);
      tick();
      in_valid = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/c17_resp_misr.md
C17_RESP_MISR -- requirements
Module: c17_resp_misr

Interface
REQ-001 The block SHALL have one parameter: SEED, default 8'h00, initial MISR value loaded at each run start.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle run request; honoured only in IDLE or DONE.
REQ-006 num_patterns  input  8  number of responses to compact; sampled on an accepted start.
REQ-007 golden  input  8  expected signature; sampled on an accepted start.
REQ-008 in_valid  input  1  resp holds a valid C17 response this cycle.
REQ-009 resp  input  2  C17 outputs: bit0 = 22GAT, bit1 = 23GAT.
REQ-010 in_ready  output  1  high exactly while in RUN.
REQ-011 busy  output  1  high exactly while in RUN.
REQ-012 done  output  1  high exactly while in DONE.
REQ-013 signature  output  8  current MISR contents.
REQ-014 pass  output  1  registered (signature == golden) result; valid only while done = 1.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 IDLE + start + num_patterns != 0 SHALL transition to RUN on the next cycle, with signature = SEED, the count loaded with num_patterns, and golden captured.
REQ-017 IDLE + start + num_patterns == 0 SHALL transition to DONE on the next cycle, with signature = SEED and pass = (SEED == golden).
REQ-018 In RUN, each cycle with in_valid = 1 SHALL apply one MISR update and decrement the count by 1.
REQ-019 In RUN, a cycle with in_valid = 0 SHALL leave signature and count unchanged, with no timeout.
REQ-020 The MISR update SHALL be: fb = s[7]^s[5]^s[4]^s[3]; s_next = {s[6:0], fb} ^ {6'b0, resp}.
REQ-021 An accepted in_valid cycle with count == 1 SHALL apply the final update and transition to DONE on the next cycle.
REQ-022 pass SHALL be computed from the final signature and be valid in the first DONE cycle.
REQ-023 In DONE, signature and pass SHALL hold until start or rst.
REQ-024 start in DONE SHALL begin a new run with the same rules as start in IDLE.
REQ-025 start while in RUN SHALL be ignored: no reload of count, golden or signature.
REQ-026 in_valid outside RUN SHALL be ignored.
REQ-027 Latency SHALL be one cycle from each accepted response to the updated signature, and one cycle from the last accepted response to done = 1.
REQ-028 The count SHALL be an 8-bit unsigned value that never underflows; num_patterns = 255 SHALL yield exactly 255 updates.

Reset
REQ-029 rst = 1 SHALL force, on the next edge, state = IDLE, signature = 8'h00, count = 0, captured golden = 0, pass = 0, and in_ready = busy = done = 0.
REQ-030 rst SHALL take priority over start and in_valid in the same cycle.
REQ-031 rst asserted mid-RUN SHALL abort the run with no done pulse, and reset values SHALL appear on the next cycle.
REQ-032 After rst deasserts, the block SHALL accept start on the first following cycle.

Verification
REQ-033 SEED = 0, start with num_patterns = 1, golden = 8'h01, then resp = 2'b01 with in_valid -> signature = 8'h01, done = 1, pass = 1 on the following cycle.
REQ-034 num_patterns = 2, resp 2'b01 then 2'b10 -> signature 8'h01 then 8'h00; with golden = 8'h05 -> done = 1, pass = 0.
REQ-035 num_patterns = 3, resp = 2'b11 on three non-consecutive valid cycles (in_valid gaps) -> signature steps 8'h03, 8'h05, 8'h09 and holds across gaps; with golden = 8'h09 -> done = 1, pass = 1.
REQ-036 start with num_patterns = 0, golden = 8'h00 -> DONE the next cycle, signature = 8'h00, pass = 1, busy never high.
REQ-037 rst asserted after 1 of 3 responses -> IDLE next cycle, signature = 8'h00, done = 0; a subsequent run completes normally.
REQ-038 start pulsed mid-RUN, and in_valid pulsed in IDLE/DONE -> no change to count, signature or golden.
